// File: rtl/axi_mem_arbiter.sv
// ---------------------------------------------------------------------------
// axi_mem_arbiter
// Two-requester arbiter plus native (PicoRV32-style valid/ready) to AXI4-Lite
// bridge in front of the shared test memory. One transaction at a time.
//
// Ports
//   clk, resetn            : clock (rising edge) / async active-low reset
//   pN_valid/instr/addr/   : native request from port N (N = 0 core, 1 loader)
//   pN_wdata/wstrb         :   wstrb != 0 means write, wstrb == 0 means read
//   pN_ready/rdata         : one-cycle completion pulse and read data
//   mem_axi_*              : single AXI4-Lite master port (AW/W/B/AR/R)
//   grant                  : port currently or most recently granted
//   busy                   : a transaction is in flight
//   timeout_err            : sticky watchdog flag (TIMEOUT cycles in ADDR+RESP)
// ---------------------------------------------------------------------------
module axi_mem_arbiter #(
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 0,
  parameter int TIMEOUT_W   = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        p0_valid,
  input  logic        p0_instr,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wstrb,
  output logic        p0_ready,
  output logic [31:0] p0_rdata,
  input  logic        p1_valid,
  input  logic        p1_instr,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wstrb,
  output logic        p1_ready,
  output logic [31:0] p1_rdata,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata,
  output logic        grant,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP, S_DONE} state_t;

  localparam logic [TIMEOUT_W-1:0] CNT_ONE = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX = {TIMEOUT_W{1'b1}};
  localparam logic [TIMEOUT_W-1:0] TO_L    = TIMEOUT_W'(TIMEOUT);

  state_t r_state, w_state_nxt;

  logic                 r_awvalid, r_wvalid, r_arvalid, r_bready, r_rready;
  logic                 r_p0_ready, r_p1_ready, r_grant, r_last_grant, r_busy;
  logic                 r_instr, r_tout;
  logic [31:0]          r_addr, r_wdata, r_p0_rdata, r_p1_rdata;
  logic [3:0]           r_wstrb;
  logic [TIMEOUT_W-1:0] r_cnt;

  logic                 w_awvalid_nxt, w_wvalid_nxt, w_arvalid_nxt, w_bready_nxt, w_rready_nxt;
  logic                 w_p0_ready_nxt, w_p1_ready_nxt, w_grant_nxt, w_last_grant_nxt, w_busy_nxt;
  logic                 w_instr_nxt, w_tout_nxt, w_sel, w_hit;
  logic [31:0]          w_addr_nxt, w_wdata_nxt, w_p0_rdata_nxt, w_p1_rdata_nxt;
  logic [3:0]           w_wstrb_nxt;
  logic [TIMEOUT_W-1:0] w_cnt_nxt, w_cnt_inc;

  // Next-state and next-output logic for the whole transaction sequence.
  always_comb begin
    w_state_nxt      = r_state;
    w_awvalid_nxt    = r_awvalid;
    w_wvalid_nxt     = r_wvalid;
    w_arvalid_nxt    = r_arvalid;
    w_bready_nxt     = r_bready;
    w_rready_nxt     = r_rready;
    w_p0_ready_nxt   = 1'b0;
    w_p1_ready_nxt   = 1'b0;
    w_p0_rdata_nxt   = r_p0_rdata;
    w_p1_rdata_nxt   = r_p1_rdata;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_wstrb_nxt      = r_wstrb;
    w_instr_nxt      = r_instr;
    w_cnt_nxt        = r_cnt;
    w_tout_nxt       = r_tout;

    // Winner: on contention, round-robin picks the port not served last.
    if (p0_valid && p1_valid) begin
      if (ROUND_ROBIN != 0) begin
        w_sel = ~r_last_grant;
      end else begin
        w_sel = 1'b0;
      end
    end else if (p1_valid) begin
      w_sel = 1'b1;
    end else begin
      w_sel = 1'b0;
    end

    // Watchdog counts every cycle spent in ADDR/RESP and saturates.
    if (r_cnt == CNT_MAX) begin
      w_cnt_inc = r_cnt;
    end else begin
      w_cnt_inc = r_cnt + CNT_ONE;
    end
    w_hit = (TIMEOUT != 0) && (w_cnt_inc == TO_L);

    case (r_state)
      S_IDLE: begin
        if (p0_valid || p1_valid) begin
          w_state_nxt      = S_ADDR;
          w_grant_nxt      = w_sel;
          w_last_grant_nxt = w_sel;
          w_addr_nxt       = w_sel ? p1_addr  : p0_addr;
          w_wdata_nxt      = w_sel ? p1_wdata : p0_wdata;
          w_wstrb_nxt      = w_sel ? p1_wstrb : p0_wstrb;
          w_instr_nxt      = w_sel ? p1_instr : p0_instr;
          w_cnt_nxt        = {TIMEOUT_W{1'b0}};
          if (w_wstrb_nxt != 4'h0) begin
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
          end else begin
            w_arvalid_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ADDR: begin
        w_cnt_nxt  = w_cnt_inc;
        w_tout_nxt = r_tout | w_hit;
        if (r_wstrb != 4'h0) begin
          // AW and W retire independently; move on once both have gone.
          w_awvalid_nxt = r_awvalid & ~mem_axi_awready;
          w_wvalid_nxt  = r_wvalid & ~mem_axi_wready;
          if (!w_awvalid_nxt && !w_wvalid_nxt) begin
            w_bready_nxt = 1'b1;
            w_state_nxt  = S_RESP;
          end else begin
            w_state_nxt  = S_ADDR;
          end
        end else begin
          if (r_arvalid && mem_axi_arready) begin
            w_arvalid_nxt = 1'b0;
            w_rready_nxt  = 1'b1;
            w_state_nxt   = S_RESP;
          end else begin
            w_state_nxt   = S_ADDR;
          end
        end
      end
      S_RESP: begin
        w_cnt_nxt  = w_cnt_inc;
        w_tout_nxt = r_tout | w_hit;
        if (r_bready && mem_axi_bvalid) begin
          w_bready_nxt = 1'b0;
          w_state_nxt  = S_DONE;
          if (r_grant) begin
            w_p1_ready_nxt = 1'b1;
          end else begin
            w_p0_ready_nxt = 1'b1;
          end
        end else if (r_rready && mem_axi_rvalid) begin
          w_rready_nxt = 1'b0;
          w_state_nxt  = S_DONE;
          if (r_grant) begin
            w_p1_ready_nxt = 1'b1;
            w_p1_rdata_nxt = mem_axi_rdata;
          end else begin
            w_p0_ready_nxt = 1'b1;
            w_p0_rdata_nxt = mem_axi_rdata;
          end
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      // Ready pulses during DONE; valid is deliberately not sampled here.
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs and latched request payload.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_bready     <= 1'b0;
      r_rready     <= 1'b0;
      r_p0_ready   <= 1'b0;
      r_p1_ready   <= 1'b0;
      r_p0_rdata   <= 32'h0;
      r_p1_rdata   <= 32'h0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_busy       <= 1'b0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_wstrb      <= 4'h0;
      r_instr      <= 1'b0;
      r_cnt        <= {TIMEOUT_W{1'b0}};
      r_tout       <= 1'b0;
    end else begin
      r_awvalid    <= w_awvalid_nxt;
      r_wvalid     <= w_wvalid_nxt;
      r_arvalid    <= w_arvalid_nxt;
      r_bready     <= w_bready_nxt;
      r_rready     <= w_rready_nxt;
      r_p0_ready   <= w_p0_ready_nxt;
      r_p1_ready   <= w_p1_ready_nxt;
      r_p0_rdata   <= w_p0_rdata_nxt;
      r_p1_rdata   <= w_p1_rdata_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_busy       <= w_busy_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_wstrb      <= w_wstrb_nxt;
      r_instr      <= w_instr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_tout       <= w_tout_nxt;
    end
  end

  assign mem_axi_awvalid = r_awvalid;
  assign mem_axi_awaddr  = r_addr;
  assign mem_axi_awprot  = 3'b000;
  assign mem_axi_wvalid  = r_wvalid;
  assign mem_axi_wdata   = r_wdata;
  assign mem_axi_wstrb   = r_wstrb;
  assign mem_axi_bready  = r_bready;
  assign mem_axi_arvalid = r_arvalid;
  assign mem_axi_araddr  = r_addr;
  assign mem_axi_arprot  = {r_instr, 2'b00};
  assign mem_axi_rready  = r_rready;
  assign p0_ready        = r_p0_ready;
  assign p0_rdata        = r_p0_rdata;
  assign p1_ready        = r_p1_ready;
  assign p1_rdata        = r_p1_rdata;
  assign grant           = r_grant;
  assign busy            = r_busy;
  assign timeout_err     = r_tout;

endmodule

// File: doc/axi_mem_arbiter.md
Name: axi_mem_arbiter

Overview:
Two-requester arbiter and native-to-AXI4-Lite bridge in front of the shared test memory. Requesters use the PicoRV32 native memory handshake (core port and a debug/DMA loader port); the block grants one at a time and drives a single AXI4-Lite master port into the memory. Transactions are strictly serialised, one outstanding at most; no ID or reordering support.

Parameters:
ROUND_ROBIN, 1, 1 = alternate grant on contention; 0 = port 0 fixed priority
TIMEOUT, 0, cycles allowed in ADDR+RESP before timeout_err sets; 0 disables watchdog
TIMEOUT_W, 16, width of watchdog counter

Ports:
clk  in  1  clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
p0_valid, p1_valid  in  1 each  request; held with payload stable until matching pN_ready
p0_instr, p1_instr  in  1 each  instruction fetch qualifier
p0_addr, p1_addr  in  32 each  byte address
p0_wdata, p1_wdata  in  32 each  write data
p0_wstrb, p1_wstrb  in  4 each  byte enables; nonzero = write, zero = read
p0_ready, p1_ready  out  1 each  one-cycle completion pulse
p0_rdata, p1_rdata  out  32 each  read data, valid in the pNready cycle
mem_axi_awvalid/awready/awaddr/awprot  out/in/out/out  1/1/32/3  write address channel
mem_axi_wvalid/wready/wdata/wstrb  out/in/out/out  1/1/32/4  write data channel
mem_axi_bvalid/bready  in/out  1/1  write response channel
mem_axi_arvalid/arready/araddr/arprot  out/in/out/out  1/1/32/3  read address channel
mem_axi_rvalid/rready/rdata  in/out/in  1/1/32  read data channel
grant  out  1  port currently or last granted
busy  out  1  state != IDLE
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (async, immediate): state IDLE; all valid/ready outputs 0; addr/data/rdata outputs 0; grant=0; busy=0; timeout_err=0; last_grant=1 so port 0 wins first contention.
- FSM IDLE -> ADDR -> RESP -> DONE -> IDLE; all outputs registered.
- IDLE: pick winner among valid requests.
  - ROUND_ROBIN=1: contention grants the port != last_grant.
  - ROUND_ROBIN=0: port 0 always wins.
  - Latch addr/wdata/wstrb/instr of the winner; update grant and last_grant; go ADDR.
- ADDR, write: awvalid and wvalid asserted together.
  - Each deasserts independently on its own valid&ready edge.
  - When both have handshaken (same or different cycles), go RESP with bready=1.
- ADDR, read: arvalid held until arready; then RESP with rready=1.
- awprot=3'b000. arprot=3'b100 if latched instr, else 3'b000. awaddr/araddr = latched addr; wstrb/wdata latched.
- RESP: on bvalid&bready or rvalid&rready:
  - drop bready/rready;
  - capture rdata into the granted pN_rdata (writes leave it unchanged);
  - go DONE.
  - Response codes are not present and are ignored.
- DONE: granted pN_ready=1 for exactly one cycle; other port's ready stays 0; next IDLE. Requester's valid is not re-sampled in DONE, so a requester dropping valid the cycle after ready is never double-granted.
- Latency: valid seen in IDLE at cycle 0 -> AXI valid at 1 -> with zero-wait slave, response handshake at 2 -> pN_ready at 3. Each slave stall cycle adds one.
- Requester deasserting valid mid-transaction: protocol violation; transaction still completes and ready still pulses.
- Watchdog:
  - Counter clears on entry to ADDR and increments each cycle in ADDR/RESP.
  - When it reaches TIMEOUT (TIMEOUT!=0), timeout_err sets and stays set until reset.
  - The transaction is not abandoned; the FSM keeps waiting.
  - Counter saturates at all-ones.
- Reset mid-transaction: transaction discarded, no ready pulse; requester must reissue after resetn rises.

Test Plan:
1. Port 0 read, addr 0x100, instr=1, memory 0x12345678, zero-wait slave -> arvalid cycle 1 with arprot=3'b100; p0_ready cycle 3 with p0_rdata=0x12345678; p1_ready never asserted.
2. Port 1 write, addr 0x200, wdata 0xAABBCCDD, wstrb 4'hF; wready immediate, awready delayed 2 cycles -> wvalid high 1 cycle, awvalid high 3 cycles; then bready; single p1_ready; memory word 0x200 = 0xAABBCCDD.
3. ROUND_ROBIN=1, both ports continuously requesting after reset -> grants 0,1,0,1 for four transactions; each ready pulses once per grant.
4. ROUND_ROBIN=0, port 0 reissues every cycle after ready and port 1 waits -> port 1 never granted during 8 port-0 transactions; granted once port 0 idles.
5. resetn low for 1 cycle during RESP of a port-0 read -> all AXI valids/readies and p0_ready 0 immediately; after release, reissued read returns correct data with normal 3-cycle latency.
6. TIMEOUT=16, slave holds rvalid=0 -> timeout_err rises after 16 cycles in ADDR/RESP and stays 1, busy=1; late rvalid completes the read normally and timeout_err stays 1 until reset.
